// File: rtl/memport_req_queue.sv
`default_nettype none
// ============================================================================
//  Module      : memport_req_queue
//  Description : Request queue behind the 32b CGRA memory port. It captures
//                the port's per-cycle request into an in-order FIFO and
//                issues it over a valid/ready channel. It also counts
//                outstanding reads and keeps the most recent read data.
//  Revision    : 1.0  initial release
// ============================================================================
module memport_req_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int MAX_RD     = 4
) (
    input  logic                  CGRA_Clock,
    input  logic                  CGRA_Reset,
    input  logic                  enable,
    input  logic                  write_rq,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] to_mem,
    output logic [DATA_WIDTH-1:0] from_mem,
    output logic                  stall,
    output logic                  busy,
    output logic                  overflow,
    output logic                  resp_err,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_we,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [DATA_WIDTH-1:0] mem_req_wdata,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_resp_rdata
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int RD_W  = $clog2(MAX_RD + 1);

    localparam logic [CNT_W-1:0] C_FULL_CNT = CNT_W'(DEPTH);
    localparam logic [RD_W-1:0]  C_RD_MAX   = RD_W'(MAX_RD);

    // FIFO storage; contents are only observed while count_q is non-zero
    logic                  fifo_we_q    [DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_addr_q  [DEPTH];
    logic [DATA_WIDTH-1:0] fifo_wdata_q [DEPTH];

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [RD_W-1:0]       rd_out_q, rd_out_d;
    logic [DATA_WIDTH-1:0] from_mem_q, from_mem_d;
    logic                  overflow_q, overflow_d;
    logic                  resp_err_q, resp_err_d;

    logic not_empty;
    logic head_is_read;
    logic do_enq;
    logic do_deq;
    logic rd_issue;
    logic resp_ok;

    // Handshake qualifiers; the read limit uses the registered rd_out_q, so a
    // response freeing a slot only unblocks a read head on the next cycle
    always_comb begin
        not_empty     = (count_q != '0);
        head_is_read  = !fifo_we_q[rd_ptr_q];
        stall         = (count_q == C_FULL_CNT);
        mem_req_valid = not_empty && !(head_is_read && (rd_out_q == C_RD_MAX));
        do_enq        = enable && !stall;
        do_deq        = mem_req_valid && mem_req_ready;
        rd_issue      = do_deq && head_is_read;
        resp_ok       = mem_resp_valid && (rd_out_q != '0);
    end

    // Next-state for pointers, occupancy, read tracking and sticky flags
    always_comb begin
        wr_ptr_d   = do_enq ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = do_deq ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d    = count_q;
        if (do_enq && !do_deq) begin
            count_d = count_q + CNT_W'(1);
        end else if (!do_enq && do_deq) begin
            count_d = count_q - CNT_W'(1);
        end
        rd_out_d   = rd_out_q;
        if (rd_issue && !resp_ok) begin
            rd_out_d = rd_out_q + RD_W'(1);
        end else if (!rd_issue && resp_ok) begin
            rd_out_d = rd_out_q - RD_W'(1);
        end
        from_mem_d = resp_ok ? mem_resp_rdata : from_mem_q;
        overflow_d = overflow_q || (enable && stall);
        resp_err_d = resp_err_q || (mem_resp_valid && (rd_out_q == '0));
    end

    // Control state register with asynchronous active-low reset
    always_ff @(posedge CGRA_Clock or negedge CGRA_Reset) begin
        if (!CGRA_Reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_out_q   <= '0;
            from_mem_q <= '0;
            overflow_q <= 1'b0;
            resp_err_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_out_q   <= rd_out_d;
            from_mem_q <= from_mem_d;
            overflow_q <= overflow_d;
            resp_err_q <= resp_err_d;
        end
    end

    // Request capture into the slot addressed by the write pointer
    always_ff @(posedge CGRA_Clock) begin
        if (do_enq) begin
            fifo_we_q[wr_ptr_q]    <= write_rq;
            fifo_addr_q[wr_ptr_q]  <= addr;
            fifo_wdata_q[wr_ptr_q] <= to_mem;
        end
    end

    // Head entry falls through to the request channel; zero when empty
    always_comb begin
        mem_req_we    = 1'b0;
        mem_req_addr  = '0;
        mem_req_wdata = '0;
        if (not_empty) begin
            mem_req_we    = fifo_we_q[rd_ptr_q];
            mem_req_addr  = fifo_addr_q[rd_ptr_q];
            mem_req_wdata = fifo_wdata_q[rd_ptr_q];
        end
        from_mem = from_mem_q;
        overflow = overflow_q;
        resp_err = resp_err_q;
        busy     = not_empty || (rd_out_q != '0);
    end

endmodule
`default_nettype wire

// File: tb/tb_memport_req_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_memport_req_queue
//  Description : Directed, table-driven self-checking bench for
//                memport_req_queue (DEPTH=4, MAX_RD=4).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_memport_req_queue;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        write_rq;
    logic [31:0] addr;
    logic [31:0] to_mem;
    logic [31:0] from_mem;
    logic        stall;
    logic        busy;
    logic        overflow;
    logic        resp_err;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_we;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;

    int n_pass;
    int n_total;

    memport_req_queue #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .DEPTH     (4),
        .MAX_RD    (4)
    ) dut (
        .CGRA_Clock    (clk),
        .CGRA_Reset    (rst_n),
        .enable        (enable),
        .write_rq      (write_rq),
        .addr          (addr),
        .to_mem        (to_mem),
        .from_mem      (from_mem),
        .stall         (stall),
        .busy          (busy),
        .overflow      (overflow),
        .resp_err      (resp_err),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_we    (mem_req_we),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wdata (mem_req_wdata),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_rdata(mem_resp_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
        logic        rdy;
        logic        rv;
        logic [31:0] rd;
        logic        e_stall;
        logic        e_busy;
        logic        e_ovf;
        logic        e_err;
        logic        e_val;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [31:0] e_from;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic en, input logic wr, input logic [31:0] a,
                                input logic [31:0] d, input logic rdy, input logic rv,
                                input logic [31:0] rd, input logic st, input logic bz,
                                input logic ov, input logic er, input logic val,
                                input logic we, input logic [31:0] ea,
                                input logic [31:0] ew, input logic [31:0] ef);
        vec_t v;
        v.en = en; v.wr = wr; v.a = a; v.d = d; v.rdy = rdy; v.rv = rv; v.rd = rd;
        v.e_stall = st; v.e_busy = bz; v.e_ovf = ov; v.e_err = er; v.e_val = val;
        v.e_we = we; v.e_addr = ea; v.e_wdata = ew; v.e_from = ef;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic rdy, input logic rv,
                         input logic [31:0] rd);
        enable = en; write_rq = wr; addr = a; to_mem = d;
        mem_req_ready = rdy; mem_resp_valid = rv; mem_resp_rdata = rd;
    endtask

    function automatic logic [127:0] all_outs();
        return {26'd0, from_mem, stall, busy, overflow, resp_err,
                mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata};
    endfunction

    localparam logic [31:0] F = 32'h1234_5678;
    localparam logic [31:0] G = 32'h55AA_55AA;

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);

        // Inputs:  en wr addr  wdata  rdy rv rdata | exp: stall busy ovf err val we addr wdata from_mem
        tbl.push_back(mk(0,0,32'h0,  32'h0,       0,0,32'h0,        0,0,0,0,0,0,32'h0,  32'h0,       32'h0));
        tbl.push_back(mk(1,1,32'h100,32'hDEADBEEF,1,0,32'h0,        0,0,0,0,0,0,32'h0,  32'h0,       32'h0));
        tbl.push_back(mk(0,0,32'h0,  32'h0,       1,0,32'h0,        0,1,0,0,1,1,32'h100,32'hDEADBEEF,32'h0));
        tbl.push_back(mk(1,0,32'h40, 32'h0,       1,0,32'h0,        0,0,0,0,0,0,32'h0,  32'h0,       32'h0));
        tbl.push_back(mk(0,0,32'h0,  32'h0,       1,0,32'h0,        0,1,0,0,1,0,32'h40, 32'h0,       32'h0));
        tbl.push_back(mk(0,0,32'h0,  32'h0,       0,0,32'h0,        0,1,0,0,0,0,32'h0,  32'h0,       32'h0));
        tbl.push_back(mk(0,0,32'h0,  32'h0,       0,0,32'h0,        0,1,0,0,0,0,32'h0,  32'h0,       32'h0));
        tbl.push_back(mk(0,0,32'h0,  32'h0,       0,1,F,            0,1,0,0,0,0,32'h0,  32'h0,       32'h0));
        tbl.push_back(mk(0,0,32'h0,  32'h0,       0,0,32'h0,        0,0,0,0,0,0,32'h0,  32'h0,       F));
        tbl.push_back(mk(0,0,32'h0,  32'h0,       0,1,32'hBAD0BAD0, 0,0,0,0,0,0,32'h0,  32'h0,       F));
        tbl.push_back(mk(0,0,32'h0,  32'h0,       0,0,32'h0,        0,0,0,1,0,0,32'h0,  32'h0,       F));
        tbl.push_back(mk(1,1,32'h200,32'hA0,      0,0,32'h0,        0,0,0,1,0,0,32'h0,  32'h0,       F));
        tbl.push_back(mk(1,1,32'h204,32'hA1,      0,0,32'h0,        0,1,0,1,1,1,32'h200,32'hA0,      F));
        tbl.push_back(mk(1,1,32'h208,32'hA2,      0,0,32'h0,        0,1,0,1,1,1,32'h200,32'hA0,      F));
        tbl.push_back(mk(1,1,32'h20C,32'hA3,      0,0,32'h0,        0,1,0,1,1,1,32'h200,32'hA0,      F));
        tbl.push_back(mk(1,1,32'h210,32'hA4,      0,0,32'h0,        1,1,0,1,1,1,32'h200,32'hA0,      F));
        tbl.push_back(mk(0,0,32'h0,  32'h0,       1,0,32'h0,        1,1,1,1,1,1,32'h200,32'hA0,      F));
        tbl.push_back(mk(0,0,32'h0,  32'h0,       1,0,32'h0,        0,1,1,1,1,1,32'h204,32'hA1,      F));
        tbl.push_back(mk(0,0,32'h0,  32'h0,       1,0,32'h0,        0,1,1,1,1,1,32'h208,32'hA2,      F));
        tbl.push_back(mk(0,0,32'h0,  32'h0,       1,0,32'h0,        0,1,1,1,1,1,32'h20C,32'hA3,      F));
        tbl.push_back(mk(0,0,32'h0,  32'h0,       1,0,32'h0,        0,0,1,1,0,0,32'h0,  32'h0,       F));
        tbl.push_back(mk(1,0,32'h300,32'h0,       1,0,32'h0,        0,0,1,1,0,0,32'h0,  32'h0,       F));
        tbl.push_back(mk(1,0,32'h304,32'h0,       1,0,32'h0,        0,1,1,1,1,0,32'h300,32'h0,       F));
        tbl.push_back(mk(1,0,32'h308,32'h0,       1,0,32'h0,        0,1,1,1,1,0,32'h304,32'h0,       F));
        tbl.push_back(mk(1,0,32'h30C,32'h0,       1,0,32'h0,        0,1,1,1,1,0,32'h308,32'h0,       F));
        tbl.push_back(mk(1,0,32'h310,32'h0,       1,0,32'h0,        0,1,1,1,1,0,32'h30C,32'h0,       F));
        tbl.push_back(mk(1,0,32'h314,32'h0,       1,0,32'h0,        0,1,1,1,0,0,32'h310,32'h0,       F));
        tbl.push_back(mk(0,0,32'h0,  32'h0,       1,1,G,            0,1,1,1,0,0,32'h310,32'h0,       F));
        tbl.push_back(mk(0,0,32'h0,  32'h0,       1,0,32'h0,        0,1,1,1,1,0,32'h310,32'h0,       G));
        tbl.push_back(mk(0,0,32'h0,  32'h0,       1,1,32'h11,       0,1,1,1,0,0,32'h314,32'h0,       G));
        tbl.push_back(mk(0,0,32'h0,  32'h0,       1,1,32'h22,       0,1,1,1,1,0,32'h314,32'h0,       32'h11));
        tbl.push_back(mk(0,0,32'h0,  32'h0,       0,0,32'h0,        0,1,1,1,0,0,32'h0,  32'h0,       32'h22));

        // Reset held with random inputs: every output stays zero
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(1'($urandom), 1'($urandom), $urandom, $urandom,
                  1'($urandom), 1'($urandom), $urandom);
            #1;
            chk($sformatf("reset_outs%0d", i), all_outs(), 128'd0);
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("post_reset_stall", 128'(stall), 128'd0);
        chk("post_reset_busy",  128'(busy),  128'd0);

        // Cycle-by-cycle vectors; outputs are checked before the edge that consumes the inputs
        foreach (tbl[r]) begin
            @(negedge clk);
            drive(tbl[r].en, tbl[r].wr, tbl[r].a, tbl[r].d, tbl[r].rdy, tbl[r].rv, tbl[r].rd);
            #1;
            chk($sformatf("r%0d.stall", r), 128'(stall),         128'(tbl[r].e_stall));
            chk($sformatf("r%0d.busy",  r), 128'(busy),          128'(tbl[r].e_busy));
            chk($sformatf("r%0d.ovf",   r), 128'(overflow),      128'(tbl[r].e_ovf));
            chk($sformatf("r%0d.err",   r), 128'(resp_err),      128'(tbl[r].e_err));
            chk($sformatf("r%0d.valid", r), 128'(mem_req_valid), 128'(tbl[r].e_val));
            chk($sformatf("r%0d.we",    r), 128'(mem_req_we),    128'(tbl[r].e_we));
            chk($sformatf("r%0d.addr",  r), 128'(mem_req_addr),  128'(tbl[r].e_addr));
            chk($sformatf("r%0d.wdata", r), 128'(mem_req_wdata), 128'(tbl[r].e_wdata));
            chk($sformatf("r%0d.from",  r), 128'(from_mem),      128'(tbl[r].e_from));
        end

        // Drain the three reads still outstanding
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 1, 32'h33);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 1, 32'h44);
        #1;
        chk("drain_from33", 128'(from_mem), 128'h33);
        chk("drain_busy",   128'(busy),     128'd1);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 1, 32'h55);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("drained_busy", 128'(busy),     128'd0);
        chk("drained_from", 128'(from_mem), 128'h55);
        chk("drained_err",  128'(resp_err), 128'd1);

        // Asynchronous reset in the middle of a cycle with work queued and a read outstanding
        @(negedge clk);
        drive(1, 0, 32'h400, 0, 0, 0, 0);
        @(negedge clk);
        drive(1, 1, 32'h404, 32'hBEEF, 1, 0, 0);
        #1;
        chk("mid_head_addr", 128'(mem_req_addr), 128'h400);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("mid_head_write", 128'({busy, mem_req_valid, mem_req_we, mem_req_addr}),
            128'({1'b1, 1'b1, 1'b1, 32'h404}));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outs", all_outs(), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 1, 32'h66);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("late_resp_err",  128'(resp_err), 128'd1);
        chk("late_resp_from", 128'(from_mem), 128'd0);
        chk("late_resp_busy", 128'(busy),     128'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
